mem_arbiter: RTL and testbench

//  Shares one single-port memory between the fetch stage (PCF/RD_instr) and the memory stage
//  (ALUResultM/WriteDataM/RD_data) of the 5-stage core. Accepts one request at a time, issues it
//  on a req/gnt + rvalid bus, and returns if_stall/d_stall; the hazard unit ORs these into its stalls.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_src_t   : which requester won arbitration
package mem_arb_pkg;

  localparam int AW_DEF           = 32;
  localparam int DW_DEF           = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    I_REQ,
    D_REQ,
    I_WAIT,
    D_WAIT
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_D
  } arb_src_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the data (M) stage.
// One transaction is outstanding at a time. Data has priority, but after
// STARVE_LIMIT consecutive data grants with a fetch waiting, fetch is forced.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and register the winner's request
// I_REQ  | fetch request on the bus, waiting for mem_gnt
// D_REQ  | data request on the bus, waiting for mem_gnt
// I_WAIT | fetch accepted, waiting for mem_rvalid
// D_WAIT | data accepted, waiting for mem_rvalid
//
// Ports
//   clk, reset (sync, active-low)
//   fetch : if_req, if_addr, if_kill -> if_rdata, if_stall
//   data  : d_req, d_we, d_addr, d_wdata, d_be -> d_rdata, d_stall
//   memory: mem_req, mem_we, mem_addr, mem_wdata, mem_be -> ; mem_gnt, mem_rvalid, mem_rdata <-
//   proto_err : sticky flag for a response seen with nothing outstanding
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_kill,
  output logic [DW-1:0]   if_rdata,
  output logic            if_stall,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            proto_err
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state, state_nxt;
  arb_src_t      winner;
  logic          pick_if, pick_d;
  logic [CW-1:0] starve_cnt;
  logic          discard;

  always_comb begin
    pick_if   = if_req && (!d_req || starve_cnt == LIMIT);
    pick_d    = d_req && !pick_if;
    winner    = pick_if ? REQ_IF : REQ_D;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_if)     state_nxt = I_REQ;
        else if (pick_d) state_nxt = D_REQ;
      end
      I_REQ:   if (mem_gnt)    state_nxt = I_WAIT;
      D_REQ:   if (mem_gnt)    state_nxt = D_WAIT;
      I_WAIT:  if (mem_rvalid) state_nxt = IDLE;
      D_WAIT:  if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      starve_cnt <= '0;
      discard    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && (pick_if || pick_d)) begin
        mem_req <= 1'b1;
        if (winner == REQ_IF) begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_be    <= '1;
        end else begin
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_be    <= d_be;
        end
      end else if ((state == I_REQ || state == D_REQ) && mem_gnt) begin
        mem_req <= 1'b0;
      end

      // Counts data grants only while a fetch is actually waiting.
      if (!if_req)
        starve_cnt <= '0;
      else if (state == I_REQ && mem_gnt)
        starve_cnt <= '0;
      else if (state == D_REQ && mem_gnt && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + CW'(1);

      // A killed fetch still runs to completion on the bus; only its data is dropped.
      if (state == I_WAIT && mem_rvalid)
        discard <= 1'b0;
      else if (if_kill && (state == I_REQ || state == I_WAIT))
        discard <= 1'b1;

      if (mem_rvalid && (state == IDLE || state == I_REQ || state == D_REQ))
        proto_err <= 1'b1;
    end
  end

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;
  // if_kill is checked combinationally too so a kill coinciding with rvalid drops that response.
  assign if_stall = if_req && !(state == I_WAIT && mem_rvalid && !discard && !if_kill);
  assign d_stall  = d_req  && !(state == D_WAIT && mem_rvalid);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_kill = 1'b0;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        proto_err;

  int tests = 0;
  int fails = 0;

  // memory responder controls
  logic gnt_off = 1'b0;
  logic stray   = 1'b0;
  int   rv_lat  = 1;
  logic pend;
  int   wait_cnt;
  logic [31:0] rdata_r;

  // scoreboards
  logic [31:0] if_exp[$];
  logic [31:0] d_exp[$];
  byte         ord_exp[$];

  mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
  endfunction

  assign mem_gnt    = mem_req && !gnt_off;
  assign mem_rvalid = (pend && wait_cnt == 0) || stray;
  assign mem_rdata  = rdata_r;

  always @(posedge clk) begin
    if (!reset) begin
      pend     <= 1'b0;
      wait_cnt <= 0;
      rdata_r  <= '0;
    end else if (mem_req && mem_gnt) begin
      pend     <= 1'b1;
      wait_cnt <= rv_lat - 1;
      rdata_r  <= mem_we ? 32'h0 : init_val(mem_addr);
    end else if (pend) begin
      if (wait_cnt == 0) pend <= 1'b0;
      else wait_cnt <= wait_cnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_if(input string tag);
    int n = 0;
    #1;
    while (if_stall && n < 30) begin tick(); n++; end
    check({tag, "_timeout"}, 64'(if_stall), 64'h0);
    check({tag, "_sb"}, 64'(if_exp.size() > 0), 64'h1);
    if (!if_stall && if_exp.size() > 0) check({tag, "_rdata"}, 64'(if_rdata), 64'(if_exp.pop_front()));
  endtask

  task automatic wait_d(input string tag);
    int n = 0;
    #1;
    while (d_stall && n < 30) begin tick(); n++; end
    check({tag, "_timeout"}, 64'(d_stall), 64'h0);
    check({tag, "_sb"}, 64'(d_exp.size() > 0), 64'h1);
    if (!d_stall && d_exp.size() > 0) check({tag, "_rdata"}, 64'(d_rdata), 64'(d_exp.pop_front()));
  endtask

  initial begin
    int nd;
    int guard;
    // reset
    repeat (3) tick();
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_proto_err", 64'(proto_err), 64'h0);
    check("rst_state", 64'(dut.state), 64'(IDLE));
    reset = 1'b1;
    tick();

    // 1: fetch only, immediate gnt, rvalid one cycle later
    if_req = 1'b1; if_addr = 32'h100; if_exp.push_back(32'h00500093);
    tick();
    check("t1_mem_req", 64'(mem_req), 64'h1);
    check("t1_mem_addr", 64'(mem_addr), 64'h100);
    check("t1_mem_we", 64'(mem_we), 64'h0);
    check("t1_stall_c1", 64'(if_stall), 64'h1);
    tick();
    check("t1_stall_c2", 64'(if_stall), 64'h0);
    check("t1_sb", 64'(if_exp.size() > 0), 64'h1);
    if (if_exp.size() > 0) check("t1_rdata", 64'(if_rdata), 64'(if_exp.pop_front()));
    if_req = 1'b0;
    tick();

    // 2: simultaneous fetch and store, data first
    if_req = 1'b1; if_addr = 32'h104; if_exp.push_back(init_val(32'h104));
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'b1111;
    d_exp.push_back(32'h0);
    tick();
    check("t2_mem_we", 64'(mem_we), 64'h1);
    check("t2_mem_addr", 64'(mem_addr), 64'h200);
    check("t2_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    check("t2_mem_be", 64'(mem_be), 64'hF);
    check("t2_if_stall", 64'(if_stall), 64'h1);
    wait_d("t2_store");
    check("t2_if_stall_ack", 64'(if_stall), 64'h1);
    d_req = 1'b0; d_we = 1'b0;
    tick(); tick();
    check("t2_fetch_addr", 64'(mem_addr), 64'h104);
    check("t2_fetch_we", 64'(mem_we), 64'h0);
    wait_if("t2_fetch");
    if_req = 1'b0;
    tick();

    // 3: starvation with six back-to-back loads and a waiting fetch
    for (int k = 0; k < 4; k++) ord_exp.push_back("D");
    ord_exp.push_back("F");
    ord_exp.push_back("D");
    ord_exp.push_back("D");
    d_req = 1'b1; d_we = 1'b0; d_be = 4'b1111; d_addr = 32'h400; d_exp.push_back(init_val(32'h400));
    if_req = 1'b1; if_addr = 32'h500; if_exp.push_back(init_val(32'h500));
    nd = 0; guard = 0;
    while ((d_req || if_req) && guard < 120) begin
      tick(); guard++;
      if (d_req && !d_stall) begin
        check("t3_order_d", 64'(ord_exp.pop_front()), 64'("D"));
        check("t3_d_rdata", 64'(d_rdata), 64'(d_exp.pop_front()));
        nd++;
        if (nd == 4) check("t3_cnt_sat", 64'(dut.starve_cnt), 64'h4);
        if (nd == 6) d_req = 1'b0;
        else begin d_addr = d_addr + 32'h4; d_exp.push_back(init_val(d_addr)); end
      end else if (if_req && !if_stall) begin
        check("t3_order_f", 64'(ord_exp.pop_front()), 64'("F"));
        check("t3_if_rdata", 64'(if_rdata), 64'(if_exp.pop_front()));
        check("t3_cnt_clr", 64'(dut.starve_cnt), 64'h0);
        if_req = 1'b0;
      end
    end
    check("t3_timeout", 64'(guard < 120), 64'h1);
    check("t3_all_done", 64'(ord_exp.size()), 64'h0);
    tick();

    // 4: fetch killed in I_WAIT, refetch from the new address
    rv_lat = 2;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    tick();
    if_kill = 1'b1; if_addr = 32'h300;
    #1;
    check("t4_stall_kill", 64'(if_stall), 64'h1);
    tick();
    if_kill = 1'b0;
    #1;
    check("t4_rvalid_seen", 64'(mem_rvalid), 64'h1);
    check("t4_drop", 64'(if_stall), 64'h1);
    tick();
    check("t4_idle_stall", 64'(if_stall), 64'h1);
    tick();
    check("t4_new_addr", 64'(mem_addr), 64'h300);
    check("t4_new_req", 64'(mem_req), 64'h1);
    if_exp.push_back(init_val(32'h300));
    wait_if("t4_refetch");
    if_req = 1'b0;
    rv_lat = 1;
    tick();

    // 5: gnt withheld for 5 cycles in D_REQ
    gnt_off = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; d_be = 4'b0011; d_exp.push_back(init_val(32'h600));
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_req", 64'(mem_req), 64'h1);
      check("t5_hold_addr", 64'(mem_addr), 64'h600);
      check("t5_hold_be", 64'(mem_be), 64'h3);
      tick();
    end
    gnt_off = 1'b0;
    wait_d("t5_load");
    d_req = 1'b0;
    tick();
    check("t5_no_proto_err", 64'(proto_err), 64'h0);

    // 6: reset during D_WAIT, then stray rvalid in IDLE
    rv_lat = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'h1234_5678; d_be = 4'b1010;
    tick();
    tick();
    check("t6_in_dwait", 64'(dut.state), 64'(D_WAIT));
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
    check("t6_state", 64'(dut.state), 64'(IDLE));
    check("t6_mem_req", 64'(mem_req), 64'h0);
    check("t6_mem_we", 64'(mem_we), 64'h0);
    check("t6_mem_addr", 64'(mem_addr), 64'h0);
    check("t6_mem_wdata", 64'(mem_wdata), 64'h0);
    check("t6_mem_be", 64'(mem_be), 64'h0);
    check("t6_d_stall", 64'(d_stall), 64'h0);
    reset = 1'b1; rv_lat = 1;
    tick();
    stray = 1'b1;
    #1;
    check("t6_stray_if_stall", 64'(if_stall), 64'h0);
    check("t6_stray_d_stall", 64'(d_stall), 64'h0);
    tick();
    stray = 1'b0;
    check("t6_proto_err", 64'(proto_err), 64'h1);
    tick();
    check("t6_proto_sticky", 64'(proto_err), 64'h1);
    check("t6_state_idle", 64'(dut.state), 64'(IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
